// File: rtl/spike_synapse_integrator.sv
// Spike event receiver: buffers presynaptic events, applies weighted current with saturation,
// and decays the current once per timestep. Optional macro SYN_SAT_COUNT_EN adds a clamp counter.
module spike_synapse_integrator #(
  parameter int N          = 18,
  parameter int NUM_INPUTS = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TAU_SHIFT  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    spike_valid,
  input  logic [IDX_W-1:0]        spike_idx,
  output logic                    spike_ready,
  input  logic                    w_we,
  input  logic [IDX_W-1:0]        w_addr,
  input  logic signed [N-1:0]     w_data,
  output logic signed [N-1:0]     i_syn,
  output logic                    pending
`ifdef SYN_SAT_COUNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic signed [N-1:0] MAX_V = {1'b0, {(N - 1){1'b1}}};
  localparam logic signed [N-1:0] MIN_V = {1'b1, {(N - 1){1'b0}}};

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_INPUTS);
  endfunction

  function automatic logic [N:0] wide_add(input logic [N-1:0] a, input logic [N-1:0] b);
    return {a[N-1], a} + {b[N-1], b};
  endfunction

  function automatic logic overflowed(input logic [N:0] s);
    return s[N] ^ s[N-1];
  endfunction

  function automatic logic signed [N-1:0] clamp(input logic [N:0] s);
    logic signed [N-1:0] r;
    case ({s[N], s[N-1]})
      2'b01:   r = MAX_V;
      2'b10:   r = MIN_V;
      default: r = s[N-1:0];
    endcase
    return r;
  endfunction

  logic [IDX_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr;
  logic [PTR_W:0]          rd_ptr;
  logic [PTR_W:0]          occupancy;
  logic signed [N-1:0]     weights [NUM_INPUTS];

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [IDX_W-1:0]        head_idx;
  logic signed [N-1:0]     head_w;
  logic [N:0]              sum;
  logic                    sum_ovf;
  logic signed [N-1:0]     sum_sat;
  logic signed [N-1:0]     decayed;

  assign occupancy   = wr_ptr - rd_ptr;
  assign fifo_full   = (occupancy == DEPTH);
  assign fifo_empty  = (occupancy == '0);
  assign spike_ready = !reset && !fifo_full;
  assign pending     = !fifo_empty;
  assign push        = spike_valid && spike_ready;
  assign pop         = !step && !fifo_empty;

  // Head event weight lookup reads the table before any same-edge write lands.
  always_comb begin
    head_idx = fifo_mem[rd_ptr[PTR_W-1:0]];
    head_w   = '0;
    if (in_range(head_idx)) begin
      head_w = weights[head_idx];
    end else begin
      head_w = '0;
    end
    sum     = wide_add(i_syn, head_w);
    sum_ovf = overflowed(sum);
    sum_sat = clamp(sum);
    decayed = i_syn - (i_syn >>> TAU_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= spike_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      i_syn  <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        weights[i] <= '0;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      end
      // Timestep decay wins over event application; the head waits one more cycle.
      if (step) begin
        i_syn <= decayed;
      end else if (pop) begin
        i_syn <= sum_sat;
      end
      if (w_we && in_range(w_addr)) begin
        weights[w_addr] <= w_data;
      end
    end
  end

`ifdef SYN_SAT_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= 16'd0;
    end else if (pop && sum_ovf && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_synapse_integrator.sv
// Directed bench for spike_synapse_integrator (NUM_INPUTS = 6 to exercise the range check).
module tb_spike_synapse_integrator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic        spike_valid = 1'b0;
  logic [2:0]  spike_idx = 3'd0;
  logic        spike_ready;
  logic        w_we = 1'b0;
  logic [2:0]  w_addr = 3'd0;
  logic [17:0] w_data = 18'h0;
  logic [17:0] i_syn;
  logic        pending;
`ifdef SYN_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif

  int total = 0;
  int passed = 0;

  spike_synapse_integrator #(
    .N(18), .NUM_INPUTS(6), .IDX_W(3), .FIFO_DEPTH(4), .TAU_SHIFT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step(step),
    .spike_valid(spike_valid),
    .spike_idx(spike_idx),
    .spike_ready(spike_ready),
    .w_we(w_we),
    .w_addr(w_addr),
    .w_data(w_data),
    .i_syn(i_syn),
    .pending(pending)
`ifdef SYN_SAT_COUNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic write_w(input logic [2:0] addr, input logic [17:0] data);
    w_we = 1'b1;
    w_addr = addr;
    w_data = data;
    tick();
    w_we = 1'b0;
  endtask

  task automatic send(input logic [2:0] idx, input int n);
    spike_valid = 1'b1;
    spike_idx = idx;
    for (int i = 0; i < n; i++) tick();
    spike_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(spike_ready), 32'd0);
    chk("rst_isyn", 32'(i_syn), 32'h0);
    chk("rst_pending", 32'(pending), 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(spike_ready), 32'd1);

    // 1: single event, applied one edge after the handshake edge
    write_w(3'd2, 18'h04000);
    send(3'd2, 1);
    chk("t1_pending_q", 32'(pending), 32'd1);
    chk("t1_isyn_q", 32'(i_syn), 32'h0);
    tick();
    chk("t1_isyn", 32'(i_syn), 32'h04000);
    chk("t1_pending_done", 32'(pending), 32'd0);

    // 2: build up to 1.0 and decay twice
    send(3'd2, 3);
    tick();
    chk("t2_isyn_one", 32'(i_syn), 32'h10000);
    step = 1'b1; tick(); step = 1'b0;
    chk("t2_decay1", 32'(i_syn), 32'h0E000);
    step = 1'b1; tick(); step = 1'b0;
    chk("t2_decay2", 32'(i_syn), 32'h0C400);

    // 3a: step held high blocks pops; FIFO fills after 4 accepts
    do_reset();
    write_w(3'd1, 18'h01000);
    step = 1'b1;
    spike_valid = 1'b1;
    spike_idx = 3'd1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_ready_fill", 32'(spike_ready), 32'd1);
      tick();
    end
    chk("t3_ready_full", 32'(spike_ready), 32'd0);
    chk("t3_isyn_held", 32'(i_syn), 32'h0);
    tick();
    spike_valid = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_drain_isyn", 32'(i_syn), 32'h04000);
    chk("t3_drain_pending", 32'(pending), 32'd0);

    // 3b: six back-to-back events with pops keeping pace
    do_reset();
    write_w(3'd1, 18'h01000);
    spike_valid = 1'b1;
    spike_idx = 3'd1;
    for (int i = 0; i < 6; i++) begin
      chk("t3_ready_stream", 32'(spike_ready), 32'd1);
      tick();
    end
    spike_valid = 1'b0;
    tick();
    chk("t3_isyn_six", 32'(i_syn), 32'h06000);

    // 4: positive and negative saturation
    do_reset();
    write_w(3'd0, 18'h18000);
    send(3'd0, 2);
    tick();
    chk("t4_sat_pos", 32'(i_syn), 32'h1FFFF);
`ifdef SYN_SAT_COUNT_EN
    chk("t4_cnt_pos", 32'(sat_count), 32'd1);
`endif
    do_reset();
    write_w(3'd0, 18'h28000);
    send(3'd0, 3);
    tick();
    chk("t4_sat_neg", 32'(i_syn), 32'h20000);
`ifdef SYN_SAT_COUNT_EN
    chk("t4_cnt_neg", 32'(sat_count), 32'd2);
`endif

    // 5: step collides with a would-be pop, then out-of-range index
    do_reset();
    write_w(3'd1, 18'h01000);
    send(3'd1, 1);
    tick();
    chk("t5_isyn_base", 32'(i_syn), 32'h01000);
    send(3'd1, 1);
    step = 1'b1; tick(); step = 1'b0;
    chk("t5_decay_only", 32'(i_syn), 32'h00E00);
    chk("t5_still_pending", 32'(pending), 32'd1);
    tick();
    chk("t5_applied_late", 32'(i_syn), 32'h01E00);
    send(3'd7, 1);
    tick();
    chk("t5_oor_isyn", 32'(i_syn), 32'h01E00);
    chk("t5_oor_consumed", 32'(pending), 32'd0);

    // 6: reset with three events pending
    step = 1'b1;
    send(3'd1, 3);
    step = 1'b0;
    chk("t6_decayed", 32'(i_syn), 32'h01419);
    chk("t6_pending", 32'(pending), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_ready_in_rst", 32'(spike_ready), 32'd0);
    tick();
    chk("t6_isyn_rst", 32'(i_syn), 32'h0);
    chk("t6_pending_rst", 32'(pending), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_ready_after", 32'(spike_ready), 32'd1);
    send(3'd1, 1);
    tick();
    chk("t6_w_cleared", 32'(i_syn), 32'h0);

    // Pop on the same edge as a weight write sees the old weight
    send(3'd3, 1);
    w_we = 1'b1; w_addr = 3'd3; w_data = 18'h00100;
    tick();
    w_we = 1'b0;
    chk("rw_old_weight", 32'(i_syn), 32'h0);
    send(3'd3, 1);
    tick();
    chk("rw_new_weight", 32'(i_syn), 32'h00100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
